// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu32 between two requesters.
// Each accepted operation is registered to the ALU for one cycle, then returned on a tagged response channel.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_z,
    output logic             rsp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [2:0] F_ILLEGAL = 3'h3;

    logic [1:0] state;
    logic       last_grant;
    logic       cur_id;
    logic       idle;
    logic       grant0;
    logic       grant1;

    // On contention the requester that did not win last time gets the grant.
    assign idle       = (state == IDLE);
    assign grant0     = req0_valid && (!req1_valid || last_grant);
    assign grant1     = req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = idle && grant0;
    assign req1_ready = idle && grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_f      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_z      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_a      <= req0_a;
                        alu_b      <= req0_b;
                        alu_f      <= req0_f;
                        cur_id     <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (grant1) begin
                        alu_a      <= req1_a;
                        alu_b      <= req1_b;
                        alu_f      <= req1_f;
                        cur_id     <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    if (alu_f == F_ILLEGAL) begin
                        rsp_y   <= '0;
                        rsp_z   <= 1'b0;
                        rsp_err <= 1'b1;
                    end else begin
                        rsp_y   <= alu_y;
                        rsp_z   <= alu_z;
                        rsp_err <= 1'b0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural alu32 on the ALU port.
// Table-driven single ops plus hand sequences for contention, backpressure and reset.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_f;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_f;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        alu_z;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_err;
    logic [31:0] rsp_y;

    int checks = 0;
    int failures = 0;
    bit both_rdy = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference alu32; code 3 produces garbage so the arbiter must mask it.
    always_comb begin
        alu_y = 32'hDEAD_BEEF;
        case (alu_f)
            3'd0: alu_y = alu_a & alu_b;
            3'd1: alu_y = alu_a | alu_b;
            3'd2: alu_y = alu_a + alu_b;
            3'd4: alu_y = alu_a & ~alu_b;
            3'd5: alu_y = alu_a | ~alu_b;
            3'd6: alu_y = alu_a - alu_b;
            3'd7: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = 32'hDEAD_BEEF;
        endcase
        alu_z = (alu_y == 32'd0);
    end

    always @(negedge clk)
        if (req0_ready && req1_ready) both_rdy = 1;

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        logic        z;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_f = 0;
        req1_a = 0; req1_b = 0; req1_f = 0;
        rsp_ready = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk(name, 32'd0, 32'd1);
    endtask

    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, output logic [31:0] y, output logic z,
                          output logic err, output logic rid, output logic [1:0] lat,
                          output bit acc);
        int n;
        @(negedge clk);
        if (id) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_f = f;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_f = f;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = (n < 20);
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        @(negedge clk);
        lat[1] = rsp_valid;
        @(negedge clk);
        lat[0] = rsp_valid;
        y = rsp_y; z = rsp_z; err = rsp_err; rid = rsp_id;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] y;
    logic        z, err, rid;
    logic [1:0]  lat;
    bit          acc;
    logic [3:0]  ids;
    logic [31:0] y_first, y_second;
    logic        z_first;

    initial begin
        vecs[0] = '{0, 32'h0000_00FF, 32'h0000_0001, 3'd2, 32'h0000_0100, 0, 0};
        vecs[1] = '{1, 32'h1234_5678, 32'h8765_4321, 3'd1, 32'h9775_5779, 0, 0};
        vecs[2] = '{0, 32'h0000_0001, 32'h0000_0001, 3'd6, 32'h0000_0000, 1, 0};
        vecs[3] = '{1, 32'hFFFF_FFFF, 32'h0000_0000, 3'd7, 32'h0000_0001, 0, 0};
        vecs[4] = '{0, 32'h1111_1111, 32'h2222_2222, 3'd3, 32'h0000_0000, 0, 1};
        vecs[5] = '{1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 32'h00F0_00F0, 0, 0};
        vecs[6] = '{0, 32'hFFFF_0000, 32'hFF00_FF00, 3'd4, 32'h00FF_0000, 0, 0};
        vecs[7] = '{1, 32'h0000_0000, 32'hFFFF_FFFE, 3'd5, 32'h0000_0001, 0, 0};

        do_reset();
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_y", rsp_y, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_f", {29'd0, alu_f}, 32'd0);
        chk("idle_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].f, y, z, err, rid, lat, acc);
            chk($sformatf("v%0d_accept", i), {31'd0, acc}, 32'd1);
            chk($sformatf("v%0d_latency", i), {30'd0, lat}, 32'd1);
            chk($sformatf("v%0d_y", i), y, vecs[i].y);
            chk($sformatf("v%0d_z", i), {31'd0, z}, {31'd0, vecs[i].z});
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_id", i), {31'd0, rid}, {31'd0, vecs[i].id});
        end
        chk("alu_a_held", alu_a, 32'h0000_0000);
        chk("alu_b_held", alu_b, 32'hFFFF_FFFE);

        // Contention: both valid continuously for four operations.
        do_reset();
        @(negedge clk);
        both_rdy = 0;
        req0_valid = 1; req0_a = 32'h1; req0_b = 32'h1; req0_f = 3'd6;
        req1_valid = 1; req1_a = 32'h1234_5678; req1_b = 32'h8765_4321; req1_f = 3'd1;
        y_first = 0; y_second = 0; z_first = 0; ids = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wait_rsp("rr_timeout");
            ids[k] = rsp_id;
            if (k == 0) begin y_first = rsp_y; z_first = rsp_z; end
            if (k == 1) y_second = rsp_y;
            @(posedge clk);
            #1;
        end
        req0_valid = 0; req1_valid = 0;
        chk("rr_ids", {28'd0, ids}, 32'b1010);
        chk("rr_first_y", y_first, 32'd0);
        chk("rr_first_z", {31'd0, z_first}, 32'd1);
        chk("rr_second_y", y_second, 32'h9775_5779);
        chk("rr_one_ready", {31'd0, both_rdy}, 32'd0);

        // Backpressure: response held while rsp_ready is low.
        do_reset();
        rsp_ready = 0;
        @(negedge clk);
        req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0; req1_f = 3'd7;
        #1;
        chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);
        #1;
        req1_valid = 0;
        req0_valid = 1; req0_a = 32'h5; req0_b = 32'h3; req0_f = 3'd2;
        @(negedge clk);
        wait_rsp("bp_timeout");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_y_%0d", k), rsp_y, 32'd1);
            chk($sformatf("bp_hold_%0d", k), {30'd0, rsp_valid, rsp_id}, 32'd3);
            chk($sformatf("bp_ready_%0d", k), {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1;
        #1;
        chk("bp_ready_hs", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("bp_cleared", {31'd0, rsp_valid}, 32'd0);
        chk("bp_req0_next", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 0;
        @(negedge clk);
        wait_rsp("bp2_timeout");
        chk("bp2_y", rsp_y, 32'd8);
        @(posedge clk);
        #1;

        // Reset during EXEC of a req1 AND.
        do_reset();
        @(negedge clk);
        req1_valid = 1; req1_a = 32'hFF; req1_b = 32'h0F; req1_f = 3'd0;
        @(posedge clk);
        #1;
        req1_valid = 0;
        chk("mid_alu_a", alu_a, 32'hFF);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1;
        ids = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) ids[0] = 1;
        end
        chk("no_stale_rsp", {28'd0, ids}, 32'd0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        req0_valid = 0; req1_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu32 instance (A, B, 3-bit F, result Y, zero flag Z) between two independent requesters.
- Each requester uses a valid/ready request channel. Requests are arbitrated round-robin, operands are registered and driven to the ALU for one cycle, and Y/Z are captured into a single response channel tagged with the requester ID.
- Sits between the instruction-side/load-store-side controllers and the shared ALU.

Parameters:
- WIDTH, 32, operand/result width; must match the alu32 datapath width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_f  in  3  ALU function code
- req1_valid, req1_ready, req1_a, req1_b, req1_f: same as requester 0
- alu_a  out  WIDTH  to ALU A, registered
- alu_b  out  WIDTH  to ALU B, registered
- alu_f  out  3  to ALU F, registered
- alu_y  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_f
- alu_z  in  1  ALU zero flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response when rsp_valid&rsp_ready
- rsp_id  out  1  requester that issued the operation
- rsp_y  out  WIDTH  captured result
- rsp_z  out  1  captured zero flag
- rsp_err  out  1  illegal function code (F=3'h3)

Behaviour:
- Function codes: 0 AND, 1 OR, 2 ADD, 4 A AND ~B, 5 A OR ~B, 6 SUB, 7 SLT. Code 3 is illegal.
- Reset values (async on rst_n low): state=IDLE; alu_a, alu_b, alu_f = 0; rsp_valid=0; rsp_id=0; rsp_y=0; rsp_z=0; rsp_err=0; last_grant=1, so requester 0 wins first.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - grant = the valid requester; if both are valid, grant = the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) && grant==N. It is combinational and at most one ready is high. Ready is low in EXEC and RESP.
  - On accept: latch a/b/f into alu_a/alu_b/alu_f, latch ID, set last_grant=ID, go to EXEC.
- EXEC (exactly 1 cycle; the ALU is purely combinational):
  - At the clock edge, capture rsp_y=alu_y, rsp_z=alu_z, rsp_err=0, rsp_id=ID; set rsp_valid=1; go to RESP.
  - If the latched f==3: rsp_y=0, rsp_z=0, rsp_err=1, ignoring alu_y/alu_z.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: clear rsp_valid and go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: accept at edge T → rsp_valid high after edge T+1. Minimum 3 cycles between accepts.
- alu_a/alu_b/alu_f hold their last values outside EXEC; they are not cleared.
- Round-robin fairness: with both requesters valid continuously, grants alternate 0,1,0,1…
- A request whose valid drops before acceptance is ignored; no state is kept.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is issued, and all outputs take reset values immediately.
- Inputs reqN_a/b/f need only be stable in the accept cycle.
- Arithmetic and overflow are the ALU's responsibility; the arbiter passes all WIDTH bits unmodified.

Test Plan:
- Reset, req0 ADD a=0x000000FF b=0x00000001, rsp_ready=1 → req0_ready=1 on the accept cycle, rsp_valid 2 edges later, rsp_y=0x00000100, rsp_z=0, rsp_id=0, rsp_err=0.
- Both valid after reset: req0 SUB 0x1-0x1, req1 OR 0x12345678|0x87654321 → first response id=0, y=0, z=1; second response id=1, y=0x97755779, z=0.
- Both valid continuously for 4 operations → rsp_id sequence 0,1,0,1; never two consecutive grants to the same requester while the other is valid.
- rsp_ready held low 3 cycles during RESP with req1 SLT a=0xFFFFFFFF b=0 → rsp_y=0x00000001 held stable; req0_ready and req1_ready stay 0 until the handshake.
- req0 with f=3'h3 → rsp_err=1, rsp_y=0, rsp_z=0, rsp_id=0; the next legal op completes normally with err=0.
- rst_n asserted during EXEC of a req1 AND → rsp_valid=0 immediately; after release no stale response appears; req0 is granted first.
